// File: rtl/pipeline_stage_register.sv
// rtl/pipeline_stage_register.sv - handshaked 2-entry skid pipeline stage register with flush, forwarding tap and stall counter
module pipeline_stage_register #(
    parameter int DATA_WIDTH  = 96,
    parameter int CTRL_WIDTH  = 8,
    parameter int RD_WIDTH    = 5,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic [CTRL_WIDTH-1:0]  in_ctrl,
    input  logic [RD_WIDTH-1:0]    in_rd,
    input  logic                   in_reg_write_enable,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [CTRL_WIDTH-1:0]  out_ctrl,
    output logic [RD_WIDTH-1:0]    out_rd,
    output logic                   out_reg_write_enable,
    output logic [RD_WIDTH-1:0]    fwd_rd,
    output logic                   fwd_valid,
    output logic [COUNT_WIDTH-1:0] stall_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    // Main entry drives the outputs; skid holds the younger entry under backpressure.
    logic [DATA_WIDTH-1:0] main_data;
    logic [CTRL_WIDTH-1:0] main_ctrl;
    logic [RD_WIDTH-1:0]   main_rd;
    logic                  main_we;
    logic [DATA_WIDTH-1:0] skid_data;
    logic [CTRL_WIDTH-1:0] skid_ctrl;
    logic [RD_WIDTH-1:0]   skid_rd;
    logic                  skid_we;

    logic accept;
    logic emit;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid;

    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign emit      = out_valid & out_ready;

    // Next-state and storage-steering decisions; flush forces a bubble and drops any accept.
    always_comb begin
        next_state     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    load_main_in = 1'b1;
                    next_state   = ONE;
                end
            end
            ONE: begin
                if (accept && emit) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    load_skid  = 1'b1;
                    next_state = FULL;
                end else if (emit) begin
                    next_state = EMPTY;
                end
            end
            FULL: begin
                if (emit) begin
                    load_main_skid = 1'b1;
                    next_state     = ONE;
                end
            end
            default: next_state = EMPTY;
        endcase
        if (flush) begin
            next_state     = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    // State register; in_ready is registered from the next state so it never sees out_ready combinationally.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= next_state;
            in_ready <= (next_state != FULL);
        end
    end

    // Entry storage; flush clears the control side so stale entries can never act.
    always_ff @(posedge clock) begin
        if (reset) begin
            main_data <= '0;
            main_ctrl <= '0;
            main_rd   <= '0;
            main_we   <= 1'b0;
            skid_data <= '0;
            skid_ctrl <= '0;
            skid_rd   <= '0;
            skid_we   <= 1'b0;
        end else if (flush) begin
            main_ctrl <= '0;
            main_we   <= 1'b0;
            skid_ctrl <= '0;
            skid_we   <= 1'b0;
        end else begin
            if (load_main_in) begin
                main_data <= in_data;
                main_ctrl <= in_ctrl;
                main_rd   <= in_rd;
                main_we   <= in_reg_write_enable;
            end else if (load_main_skid) begin
                main_data <= skid_data;
                main_ctrl <= skid_ctrl;
                main_rd   <= skid_rd;
                main_we   <= skid_we;
            end
            if (load_skid) begin
                skid_data <= in_data;
                skid_ctrl <= in_ctrl;
                skid_rd   <= in_rd;
                skid_we   <= in_reg_write_enable;
            end
        end
    end

    // Saturating count of cycles where a valid head entry is held back.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_count <= '0;
        end else if (out_valid && !out_ready && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

    // Output gating: a bubble presents as a NOP, and x0 never forwards.
    always_comb begin
        out_data             = main_data;
        out_rd               = main_rd;
        out_ctrl             = out_valid ? main_ctrl : '0;
        out_reg_write_enable = out_valid & main_we;
        fwd_valid            = out_reg_write_enable & (main_rd != '0);
        fwd_rd               = fwd_valid ? main_rd : '0;
    end

endmodule

// File: tb/tb_pipeline_stage_register.sv
// tb/tb_pipeline_stage_register.sv - randomized self-checking bench against a queue reference model
module tb_pipeline_stage_register;

    localparam int DW = 96;
    localparam int CW = 8;
    localparam int RW = 5;
    localparam int NW = 4;

    logic          clock;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic [RW-1:0] in_rd;
    logic          in_reg_write_enable;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [RW-1:0] out_rd;
    logic          out_reg_write_enable;
    logic [RW-1:0] fwd_rd;
    logic          fwd_valid;
    logic [NW-1:0] stall_count;

    pipeline_stage_register #(
        .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .RD_WIDTH(RW), .COUNT_WIDTH(NW)
    ) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_ctrl(in_ctrl), .in_rd(in_rd), .in_reg_write_enable(in_reg_write_enable),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ctrl(out_ctrl), .out_rd(out_rd), .out_reg_write_enable(out_reg_write_enable),
        .fwd_rd(fwd_rd), .fwd_valid(fwd_valid), .stall_count(stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        logic [RW-1:0] rd;
        logic          we;
    } ent_t;

    ent_t q[$];
    int   m_stall;
    int   checks;
    int   errors;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                         input logic [RW-1:0] rd, input logic we, input logic ordy, input logic fl);
        in_valid            = v;
        in_data             = d;
        in_ctrl             = c;
        in_rd               = rd;
        in_reg_write_enable = we;
        out_ready           = ordy;
        flush               = fl;
    endtask

    // Model: a FIFO of at most two entries; flush empties it, reset empties it and clears the counter.
    task automatic model_update();
        bit   acc;
        bit   emt;
        ent_t e;
        acc = in_valid && (q.size() < 2);
        emt = (q.size() > 0) && out_ready;
        if (reset) begin
            q.delete();
            m_stall = 0;
        end else begin
            if (q.size() > 0 && !out_ready && m_stall < (1 << NW) - 1) m_stall++;
            if (flush) begin
                q.delete();
            end else begin
                if (emt) void'(q.pop_front());
                if (acc) begin
                    e.d = in_data; e.c = in_ctrl; e.rd = in_rd; e.we = in_reg_write_enable;
                    q.push_back(e);
                end
            end
        end
    endtask

    task automatic compare_all(input string tag);
        bit        v;
        bit        fv;
        ent_t      h;
        v = (q.size() > 0);
        if (v) h = q[0];
        fv = v && h.we && (h.rd != 0);
        check({tag, ".out_valid"}, out_valid, v);
        check({tag, ".in_ready"}, in_ready, q.size() < 2);
        check({tag, ".out_ctrl"}, out_ctrl, v ? h.c : '0);
        check({tag, ".out_we"}, out_reg_write_enable, v ? h.we : 1'b0);
        check({tag, ".fwd_valid"}, fwd_valid, fv);
        check({tag, ".fwd_rd"}, fwd_rd, fv ? h.rd : '0);
        check({tag, ".stall"}, stall_count, m_stall);
        if (v) begin
            check({tag, ".out_data"}, out_data, h.d);
            check({tag, ".out_rd"}, out_rd, h.rd);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clock);
        model_update();
        @(negedge clock);
        compare_all(tag);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        m_stall = 0;
        reset   = 1'b1;
        drive(0, '0, '0, '0, 0, 0, 0);
        step("reset");
        reset = 1'b0;

        // Reset while FULL
        drive(1, 96'hA, 8'h5A, 5'd3, 1, 0, 0);
        step("fill_a");
        drive(1, 96'hB, 8'hA5, 5'd4, 1, 0, 0);
        step("fill_b");
        check("full_in_ready", in_ready, 1'b0);
        drive(0, '0, '0, '0, 0, 0, 0);
        reset = 1'b1;
        step("mid_reset");
        reset = 1'b0;
        check("rst_out_data", out_data, '0);
        check("rst_out_rd", out_rd, '0);

        // Streaming 1..8
        for (int i = 1; i <= 8; i++) begin
            drive(1, DW'(i), CW'(i), RW'(i), 1, 1, 0);
            step("stream");
            check("stream_data", out_data, DW'(i));
        end
        drive(0, '0, '0, '0, 0, 1, 0);
        step("stream_drain");

        // Backpressure into the skid, then release
        drive(1, 96'h11, 8'h1, 5'd1, 0, 0, 0);
        step("bp_a");
        drive(1, 96'h22, 8'h2, 5'd2, 0, 0, 0);
        step("bp_b");
        drive(0, '0, '0, '0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("bp_hold");
        check("bp_head", out_data, 96'h11);
        drive(0, '0, '0, '0, 0, 1, 0);
        step("bp_rel1");
        check("bp_second", out_data, 96'h22);
        check("bp_ready_back", in_ready, 1'b1);
        step("bp_rel2");

        // Flush with a same-cycle accept
        drive(1, 96'h33, 8'hFF, 5'd7, 1, 0, 0);
        step("fl_load");
        drive(1, 96'h44, 8'hEE, 5'd8, 1, 0, 1);
        step("fl_flush");
        check("fl_bubble", out_valid, 1'b0);
        drive(0, '0, '0, '0, 0, 1, 0);
        step("fl_after");

        // Forwarding tap and x0 rule
        drive(1, 96'h55, 8'h3, 5'd5, 1, 0, 0);
        step("fwd_rd5");
        check("fwd5_valid", fwd_valid, 1'b1);
        drive(0, '0, '0, '0, 0, 1, 0);
        step("fwd_pop");
        drive(1, 96'h66, 8'h3, 5'd0, 1, 0, 0);
        step("fwd_rd0");
        check("fwd0_valid", fwd_valid, 1'b0);

        // Counter saturation: held with out_ready=0 for 20 cycles
        drive(0, '0, '0, '0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step("sat");
        check("sat_value", stall_count, 4'd15);
        drive(0, '0, '0, '0, 0, 0, 1);
        step("sat_flush");
        check("sat_kept", stall_count, 4'd15);
        reset = 1'b1;
        step("sat_reset");
        reset = 1'b0;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, {$urandom, $urandom, $urandom}, CW'($urandom),
                  RW'($urandom_range(0, 3)), 1'($urandom), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 19) == 0);
            reset = ($urandom_range(0, 99) == 0);
            step("rand");
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
